// File: rtl/alu_pkg.sv
// Shared encodings and helpers for the serial arithmetic datapath.
package alu_pkg;

  localparam logic [1:0] SEL_B    = 2'b00;
  localparam logic [1:0] SEL_NB   = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;
  localparam logic [1:0] SEL_ONES = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_arith_unit_if.sv
// Operand/result handshake bundle for serial_arith_unit.
interface serial_arith_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic [1:0]       sel_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] d_o;
  logic             cout_o;
  logic             ovf_o;
  logic             zero_o;
  logic             neg_o;

  modport master (
    output in_valid_i, a_i, b_i, cin_i, sel_i, out_ready_i,
    input  in_ready_o, out_valid_o, d_o, cout_o, ovf_o, zero_o, neg_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, cin_i, sel_i, out_ready_i,
    output in_ready_o, out_valid_o, d_o, cout_o, ovf_o, zero_o, neg_o
  );
endinterface

// File: rtl/arith_digit.sv
// Combinational DIGIT-bit ripple slice: B-operand select followed by DIGIT full adders.
module arith_digit
  import alu_pkg::*;
#(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic [1:0]       sel_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [DIGIT-1:0] bsel;
  logic [DIGIT:0]   carry;

  always_comb begin
    case (sel_i)
      SEL_B:    bsel = b_i;
      SEL_NB:   bsel = ~b_i;
      SEL_ZERO: bsel = '0;
      default:  bsel = '1;
    endcase

    carry    = '0;
    carry[0] = cin_i;
    sum_o    = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      sum_o[i]   = a_i[i] ^ bsel[i] ^ carry[i];
      carry[i+1] = (a_i[i] & bsel[i]) | (carry[i] & (a_i[i] ^ bsel[i]));
    end
  end

  assign cout_o = carry[DIGIT];
  // Carry into the slice MSB; only meaningful for overflow on the top digit.
  assign cmsb_o = carry[DIGIT-1];

endmodule

// File: rtl/serial_arith_unit.sv
// Digit-serial A + Bsel + cin unit with valid/ready handshake and registered result flags.
module serial_arith_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  serial_arith_unit_if.slave bus_io
);

  localparam int unsigned NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
  logic [1:0]       sel_q, sel_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d, zacc_q, zacc_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

  logic [DIGIT-1:0] sum;
  logic             dig_cout, dig_cmsb, last_dig;
  logic [31:0]      base;

  assign base     = 32'(cnt_q) * DIGIT;
  assign last_dig = (cnt_q == CntW'(NDIG - 1));

  arith_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a_i   (a_q[base +: DIGIT]),
    .b_i   (b_q[base +: DIGIT]),
    .sel_i (sel_q),
    .cin_i (carry_q),
    .sum_o (sum),
    .cout_o(dig_cout),
    .cmsb_o(dig_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    res_d   = res_q;
    d_d     = d_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid_i) begin
          a_d     = bus_io.a_i;
          b_d     = bus_io.b_i;
          sel_d   = bus_io.sel_i;
          carry_d = bus_io.cin_i;
          cnt_d   = '0;
          res_d   = '0;
          zacc_d  = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        res_d[base +: DIGIT] = sum;
        carry_d              = dig_cout;
        zacc_d               = zacc_q & (sum == '0);
        if (last_dig) begin
          // Visible outputs only move here, so they stay stable between ops.
          d_d     = res_d;
          cout_d  = dig_cout;
          ovf_d   = dig_cmsb ^ dig_cout;
          zero_d  = zacc_d;
          neg_d   = sum[DIGIT-1];
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (bus_io.out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      res_q   <= '0;
      d_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign bus_io.in_ready_o  = (state_q == StIdle);
  assign bus_io.out_valid_o = (state_q == StDone);
  assign bus_io.d_o         = d_q;
  assign bus_io.cout_o      = cout_q;
  assign bus_io.ovf_o       = ovf_q;
  assign bus_io.zero_o      = zero_q;
  assign bus_io.neg_o       = neg_q;

endmodule

// File: tb/tb_serial_arith_unit.sv
// Directed + random checks of serial_arith_unit at DIGIT=8, 1 and 32 against an arithmetic model.
module tb_serial_arith_unit;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic        in_ready;
    logic        out_valid;
    logic [31:0] d;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_arith_unit_if #(.WIDTH(W)) if8 ();
  serial_arith_unit_if #(.WIDTH(W)) if1 ();
  serial_arith_unit_if #(.WIDTH(W)) if32 ();

  serial_arith_unit #(.WIDTH(W), .DIGIT(8))  u_d8  (.clk_i(clk), .rst_ni(rst_n), .bus_io(if8));
  serial_arith_unit #(.WIDTH(W), .DIGIT(1))  u_d1  (.clk_i(clk), .rst_ni(rst_n), .bus_io(if1));
  serial_arith_unit #(.WIDTH(W), .DIGIT(32)) u_d32 (.clk_i(clk), .rst_ni(rst_n), .bus_io(if32));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_obs(input string tag, input obs_t o, input obs_t e);
    chk({tag, "_in_ready"},  o.in_ready,  e.in_ready);
    chk({tag, "_out_valid"}, o.out_valid, e.out_valid);
    chk({tag, "_d"},         o.d,         e.d);
    chk({tag, "_cout"},      o.cout,      e.cout);
    chk({tag, "_ovf"},       o.ovf,       e.ovf);
    chk({tag, "_zero"},      o.zero,      e.zero);
    chk({tag, "_neg"},       o.neg,       e.neg);
  endtask

  task automatic drv(input int w, input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic c, input logic [1:0] s, input logic ordy);
    case (w)
      0: begin
        if8.in_valid_i = v; if8.a_i = a; if8.b_i = b; if8.cin_i = c; if8.sel_i = s;
        if8.out_ready_i = ordy;
      end
      1: begin
        if1.in_valid_i = v; if1.a_i = a; if1.b_i = b; if1.cin_i = c; if1.sel_i = s;
        if1.out_ready_i = ordy;
      end
      default: begin
        if32.in_valid_i = v; if32.a_i = a; if32.b_i = b; if32.cin_i = c; if32.sel_i = s;
        if32.out_ready_i = ordy;
      end
    endcase
  endtask

  function automatic obs_t smp(input int w);
    obs_t o;
    case (w)
      0: o = '{if8.in_ready_o, if8.out_valid_o, if8.d_o, if8.cout_o, if8.ovf_o, if8.zero_o,
               if8.neg_o};
      1: o = '{if1.in_ready_o, if1.out_valid_o, if1.d_o, if1.cout_o, if1.ovf_o, if1.zero_o,
               if1.neg_o};
      default: o = '{if32.in_ready_o, if32.out_valid_o, if32.d_o, if32.cout_o, if32.ovf_o,
                     if32.zero_o, if32.neg_o};
    endcase
    return o;
  endfunction

  // Reference: full-precision integer sum, signed overflow from operand/result signs.
  function automatic obs_t model(input logic [31:0] a, input logic [31:0] b, input logic c,
                                 input logic [1:0] s);
    obs_t        e;
    logic [31:0] bs;
    logic [32:0] full;
    case (s)
      SEL_B:    bs = b;
      SEL_NB:   bs = 32'hFFFF_FFFF - b;
      SEL_ZERO: bs = 32'd0;
      default:  bs = 32'hFFFF_FFFF;
    endcase
    full        = 33'(a) + 33'(bs) + 33'(c);
    e.in_ready  = 1'b0;
    e.out_valid = 1'b1;
    e.d         = full[31:0];
    e.cout      = full[32];
    e.ovf       = (a[31] == bs[31]) && (full[31] != a[31]);
    e.zero      = (full[31:0] == 32'd0);
    e.neg       = full[31];
    return e;
  endfunction

  task automatic start(input int w, input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic [1:0] s, output int n, output obs_t o);
    @(negedge clk);
    drv(w, 1'b1, a, b, c, s, 1'b0);
    @(posedge clk);
    #1;
    drv(w, 1'b0, a, b, c, s, 1'b0);
    n = 0;
    o = smp(w);
    while (!o.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      o = smp(w);
    end
  endtask

  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [1:0] s, input int lat, input string tag);
    int   n;
    obs_t o, e;
    start(w, a, b, c, s, n, o);
    e = model(a, b, c, s);
    chk({tag, "_latency"}, n, lat);
    chk_obs(tag, o, e);
    drv(w, 1'b0, a, b, c, s, 1'b1);
    @(posedge clk);
    #1;
    drv(w, 1'b0, a, b, c, s, 1'b0);
    o = smp(w);
    chk({tag, "_ret_in_ready"},  o.in_ready,  1'b1);
    chk({tag, "_ret_out_valid"}, o.out_valid, 1'b0);
    chk({tag, "_held_d"},        o.d,         e.d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t        o, e;
    int          n;
    logic [31:0] ra, rb;
    logic [1:0]  rs;
    logic        rc;

    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) drv(w, 1'b0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0);
    #12;
    e = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    chk_obs("reset", smp(0), e);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 32'h7FFF_FFFF, 32'd1, 1'b0, SEL_B,    4, "add_ovf");
    run_op(0, 32'd5,         32'd7, 1'b1, SEL_NB,   4, "sub_5_7");
    run_op(0, 32'd7,         32'd5, 1'b1, SEL_NB,   4, "sub_7_5");
    run_op(0, 32'd0,         32'd9, 1'b0, SEL_ONES, 4, "dec_0");
    run_op(0, 32'd1,         32'd9, 1'b0, SEL_ONES, 4, "dec_1");
    run_op(0, 32'h1234_5678, 32'd3, 1'b1, SEL_ZERO, 4, "inc");

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1));
      rs = 2'($urandom_range(3));
      run_op(0, ra, rb, rc, rs, 4, $sformatf("rnd8_%0d", i));
    end

    // Backpressure: result held while out_ready is low, and a pulsed in_valid is ignored.
    start(0, 32'h8000_0000, 32'h8000_0000, 1'b0, SEL_B, n, o);
    e = model(32'h8000_0000, 32'h8000_0000, 1'b0, SEL_B);
    chk("bp_latency", n, 4);
    for (int k = 0; k < 3; k++) begin
      drv(0, (k == 1), 32'd11, 32'd22, 1'b0, SEL_B, 1'b0);
      @(posedge clk);
      #1;
      chk_obs($sformatf("bp_hold%0d", k), smp(0), e);
    end
    drv(0, 1'b0, 32'd0, 32'd0, 1'b0, SEL_B, 1'b1);
    @(posedge clk);
    #1;
    drv(0, 1'b0, 32'd0, 32'd0, 1'b0, SEL_B, 1'b0);
    o = smp(0);
    chk("bp_release_in_ready",  o.in_ready,  1'b1);
    chk("bp_release_out_valid", o.out_valid, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    o = smp(0);
    chk("bp_ignored_out_valid", o.out_valid, 1'b0);
    chk("bp_ignored_in_ready",  o.in_ready,  1'b1);
    chk("bp_ignored_d",         o.d,         e.d);

    // Asynchronous reset two cycles into BUSY.
    @(negedge clk);
    drv(0, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, SEL_B, 1'b0);
    @(posedge clk);
    #1;
    drv(0, 1'b0, 32'd0, 32'd0, 1'b0, SEL_B, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    e = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    chk_obs("midrst", smp(0), e);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 32'd3, 32'd4, 1'b0, SEL_B, 4, "add_3_4");

    run_op(1, 32'hFFFF_FFFF, 32'd1, 1'b0, SEL_B, 32, "d1_wrap");
    run_op(2, 32'hFFFF_FFFF, 32'd1, 1'b0, SEL_B, 1,  "d32_wrap");
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1));
      rs = 2'($urandom_range(3));
      run_op(1, ra, rb, rc, rs, 32, $sformatf("rnd1_%0d", i));
      run_op(2, ra, rb, rc, rs, 1,  $sformatf("rnd32_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_arith_unit.md
Name: serial_arith_unit

Overview:
- Parametrised multi-cycle successor to the team's 1-bit arithmetic slice.
- Processes WIDTH-bit operands DIGIT bits per clock through a DIGIT-wide ripple slice, with a registered carry between digits.
- Uses the same B-operand select (B, ~B, 0, all-ones) plus carry-in, and adds a valid/ready handshake on input and output.
- Produces carry, signed-overflow, zero and negative flags; sits as the arithmetic datapath of the multi-bit ALU.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 8, bits processed per cycle; 1 <= DIGIT <= WIDTH. Latency NDIG = WIDTH/DIGIT.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  operands/op valid.
- in_ready_o  out  1  unit can accept operands.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- cin_i  in  1  carry-in to LSB.
- sel_i  in  2  B-path select: 00 B, 01 ~B, 10 zero, 11 all-ones.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- d_o  out  WIDTH  result.
- cout_o  out  1  carry out of MSB.
- ovf_o  out  1  signed overflow.
- zero_o  out  1  d_o == 0.
- neg_o  out  1  d_o[WIDTH-1].

Behaviour:
- Reset is asynchronous and active-low on rst_ni; the single clock is clk_i.
- Reset values: state IDLE, in_ready_o=1, out_valid_o=0, d_o=0, cout_o=0, ovf_o=0, zero_o=0, neg_o=0, digit counter=0, carry register=0.
- Operations, with Bsel taken from sel_i:
  - Result = A + Bsel + cin, modulo 2^WIDTH.
  - Resulting op set: ADD (00), SUB with cin=1 (01), transfer/increment (10), decrement/transfer (11).
- IDLE state:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o: capture a_i, b_i, sel_i; load carry register with cin_i; clear counter and result shift register; go to BUSY.
- BUSY state:
  - in_ready_o=0.
  - Each cycle, process digit k (bits k*DIGIT+DIGIT-1 : k*DIGIT) of the captured operands using the current carry register.
  - Store the sum digit into the result register; carry register <= digit carry-out; k++.
  - On the cycle that processes digit NDIG-1:
    - Latch cout = final carry.
    - ovf = carry into MSB XOR carry out of MSB.
    - zero = all digits zero (accumulated flag).
    - neg = result MSB.
    - Go to DONE.
- DONE state:
  - out_valid_o=1; d_o and flags held stable.
  - in_ready_o=0; in_valid_i is ignored.
  - On out_ready_i: out_valid_o <= 0, go to IDLE.
- Timing: if operands are accepted at edge 0, out_valid_o is high after edge NDIG, i.e. NDIG cycles of latency. Throughput is one op per NDIG+2 cycles minimum.
- DIGIT==WIDTH: a single BUSY cycle, latency 1.
- Sel encoding 11 with cin=0 on A=0: result all-ones, no carry.
- Outputs d_o/flags change only when entering DONE. Between ops they hold their last value, while out_valid_o=0.
- Reset asserted mid-operation: immediate return to reset values; the partial op is discarded with no output.
- out_ready_i while out_valid_o=0: no effect.
- Counter width: $clog2(NDIG) bits, minimum 1. No wrap-around beyond NDIG-1.

Decomposition:
- Package alu_pkg:
  - sel encodings SEL_B, SEL_NB, SEL_ZERO, SEL_ONES.
  - FSM state typedef (IDLE, BUSY, DONE).
  - Helper function computing NDIG.
- Sub-module arith_digit:
  - Combinational DIGIT-bit ripple slice: B select plus DIGIT full adders.
  - Outputs sum[DIGIT], cout, and carry into its MSB (for overflow).
- Top level holds the FSM, operand/result shift registers, carry register and flag logic.

Test Plan:
- WIDTH=32, DIGIT=8, sel=00, A=0x7FFFFFFF, B=1, cin=0 -> out_valid 4 cycles after accept; d=0x80000000, cout=0, ovf=1, neg=1, zero=0.
- sel=01, cin=1, A=5, B=7 -> d=0xFFFFFFFE, cout=0, ovf=0, neg=1. Then A=7, B=5 -> d=2, cout=1.
- sel=11, cin=0: A=0 -> d=0xFFFFFFFF, cout=0. A=1 -> d=0, cout=1, zero=1.
- Backpressure: hold out_ready_i=0 for 3 cycles after out_valid -> d/flags stable, in_ready_o=0, a pulsed in_valid_i is ignored. Raise out_ready -> IDLE next cycle, in_ready_o=1.
- Assert rst_ni low 2 cycles into BUSY -> all outputs at reset values asynchronously. After release, a new ADD 3+4 completes with d=7.
- Rerun ADD 0xFFFFFFFF+1 with DIGIT=1 (latency 32) and DIGIT=32 (latency 1) -> d=0, cout=1, zero=1, ovf=0 in both.
